pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Next-generation program counter unit. Holds the PC, advances on fetch, takes relative
//  branches, loads PC via per-byte register writes, and adds subroutine call/return and
//  interrupt entry through an internal return-address stack (RAS). Sits between the control
//  FSM and the instruction-fetch path. PC_out feeds memory address generation directly.
// PARAMETERS
//  REG_WIDTH     16   PC width in bits; must be a multiple of 8
//  STACK_DEPTH   8    RAS entries; must be >= 2
//  RESET_VECTOR  0    PC value loaded on reset (REG_WIDTH bits)
//  PC_INC        REG_WIDTH/8   fetch increment in bytes
// PORTS
//  clk            in   1                       clock, all state on rising edge
//  rst            in   1                       synchronous, active-high reset
//  fetch_en       in   1                       PC <= PC + PC_INC
//  branch_en      in   1                       PC <= PC + branch_offset
//  call_en        in   1                       push PC+PC_INC; PC <= PC + branch_offset
//  ret_en         in   1                       pop RAS into PC
//  irq_en         in   1                       push PC; PC <= irq_vector
//  reg_wr_en      in   REG_WIDTH/8             per-byte-lane direct write enables
//  reg_in         in   REG_WIDTH               direct write data
//  branch_offset  in   REG_WIDTH               two's-complement offset, relative to current PC
//  irq_vector     in   REG_WIDTH               interrupt handler address
//  ras_err_clr    in   1                       clears sticky error flags
//  PC_out         out  REG_WIDTH               current PC (combinational from PC register)
//  ras_depth      out  $clog2(STACK_DEPTH+1)   valid RAS entries
//  ras_overflow   out  1                       sticky: push while full occurred
//  ras_underflow  out  1                       sticky: pop while empty occurred
// BEHAVIOUR
//  - Reset: PC <= RESET_VECTOR, ras_depth <= 0, both error flags <= 0; RAS contents don't-care.
//  - One operation per cycle; strict priority: rst > any reg_wr_en bit > irq_en > ret_en
//    > call_en > branch_en > fetch_en. Lower-priority requests in the same cycle are dropped.
//  - Latency: every update visible on PC_out the cycle after the enabling edge; no stalls.
//  - reg_wr_en: lane i writes PC[8i+7:8i] from reg_in; unselected lanes keep value; RAS untouched.
//  - All PC arithmetic is modulo 2^REG_WIDTH (0xFFFF+2 -> 0x0001 at 16 bits); no flag raised.
//  - call: pushes PC+PC_INC (return address); irq: pushes current PC (instruction not yet
//    fetched is re-executed after return).
//  - Push when full: oldest entry discarded (circular), new entry on top, ras_depth stays
//    STACK_DEPTH, ras_overflow <= 1. PC update still occurs.
//  - ret when empty: PC <= PC + PC_INC (behaves as fetch), ras_depth stays 0, ras_underflow <= 1.
//  - ras_err_clr clears both flags; if an error event occurs the same cycle, the flag sets (set wins).
//  - Flags only clear via rst or ras_err_clr.
//  - rst asserted mid-sequence overrides every other input that cycle; stack is logically emptied.
// STRUCTURE
//  - Package pc_pkg: typedef pc_op_e {PC_HOLD, PC_REGWR, PC_IRQ, PC_RET, PC_CALL, PC_BRANCH,
//    PC_FETCH}; priority encoder function returning pc_op_e; localparam LANES = REG_WIDTH/8.
//  - Sub-module return_address_stack (REG_WIDTH, STACK_DEPTH): circular buffer, top pointer,
//    depth counter, push/pop ports, full/empty, overflow/underflow pulses.
//  - Top: priority decode -> next-PC mux -> PC register; flags registered in top.
// TESTING
//  1 rst=1 for 1 cycle, RESET_VECTOR=0x0100 -> PC_out=0x0100, ras_depth=0, flags 0.
//  2 PC=0x0100; fetch x3 -> 0x0102,0x0104,0x0106; branch_offset=0xFFFA branch -> 0x0100;
//    PC=0xFFFE fetch -> 0x0000 (wrap).
//  3 PC=0x0200, call_en offset=0x0040 -> PC=0x0240, depth=1; ret_en -> PC=0x0202, depth=0.
//  4 PC=0x1234, reg_wr_en=2'b10 reg_in=0xABCD with fetch_en=1 -> PC=0xAB34 (fetch dropped);
//    irq_en+ret_en same cycle, irq_vector=0x0010 -> PC=0x0010, depth=1 (irq wins).
//  5 9 calls with STACK_DEPTH=8 -> depth=8, ras_overflow=1; 8 rets return calls 9..2 in order;
//    9th ret -> PC+2, ras_underflow=1; ras_err_clr -> both flags 0.
//  6 rst asserted mid-call sequence (depth=3) -> PC=RESET_VECTOR, depth=0; next ret underflows.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the program counter unit: operation encoding and the
// fixed-priority request decoder.
package pc_pkg;

  localparam int PKG_REG_WIDTH = 16;
  localparam int LANES         = PKG_REG_WIDTH / 8;

  typedef enum logic [2:0] {
    PC_HOLD   = 3'd0,
    PC_REGWR  = 3'd1,
    PC_IRQ    = 3'd2,
    PC_RET    = 3'd3,
    PC_CALL   = 3'd4,
    PC_BRANCH = 3'd5,
    PC_FETCH  = 3'd6
  } pc_op_e;

  function automatic pc_op_e pc_op_decode(
    input logic wr_any,
    input logic irq,
    input logic ret,
    input logic call,
    input logic branch,
    input logic fetch
  );
    pc_op_e op;
    if (wr_any)      op = PC_REGWR;
    else if (irq)    op = PC_IRQ;
    else if (ret)    op = PC_RET;
    else if (call)   op = PC_CALL;
    else if (branch) op = PC_BRANCH;
    else if (fetch)  op = PC_FETCH;
    else             op = PC_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: a push on a full stack overwrites the oldest
// entry, a pop on an empty stack leaves the state unchanged.
module return_address_stack #(
  parameter int REG_WIDTH   = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [REG_WIDTH-1:0]             push_data,
  output logic [REG_WIDTH-1:0]             pop_data,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             empty,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(STACK_DEPTH - 1);
  localparam logic [DW-1:0] FULL_CNT = DW'(STACK_DEPTH);

  logic [REG_WIDTH-1:0] mem_r [STACK_DEPTH];
  logic [PW-1:0]        top_r;      // next free slot; equals the oldest slot when full
  logic [DW-1:0]        depth_r;
  logic [PW-1:0]        top_inc_s;
  logic [PW-1:0]        top_dec_s;
  logic                 full_s;

  // wrap-around pointer arithmetic for non-power-of-two depths
  always_comb begin
    top_inc_s = (top_r == LAST_IDX) ? {PW{1'b0}} : top_r + 1'b1;
    top_dec_s = (top_r == {PW{1'b0}}) ? LAST_IDX : top_r - 1'b1;
  end

  assign full_s    = (depth_r == FULL_CNT);
  assign empty     = (depth_r == {DW{1'b0}});
  assign depth     = depth_r;
  assign pop_data  = mem_r[top_dec_s];
  assign overflow  = push & full_s;
  assign underflow = pop & ~push & empty;

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      top_r   <= {PW{1'b0}};
      depth_r <= {DW{1'b0}};
    end else if (push) begin
      top_r <= top_inc_s;
      if (!full_s) depth_r <= depth_r + 1'b1;
    end else if (pop && !empty) begin
      top_r   <= top_dec_s;
      depth_r <= depth_r - 1'b1;
    end
  end

  // entry storage, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push && !rst) mem_r[top_r] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter unit: prioritised next-PC selection, per-lane direct writes,
// call/return/interrupt through a return-address stack, sticky stack error flags.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                   REG_WIDTH    = 16,
  parameter int                   STACK_DEPTH  = 8,
  parameter logic [REG_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                   PC_INC       = REG_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fetch_en,
  input  logic                             branch_en,
  input  logic                             call_en,
  input  logic                             ret_en,
  input  logic                             irq_en,
  input  logic [REG_WIDTH/8-1:0]           reg_wr_en,
  input  logic [REG_WIDTH-1:0]             reg_in,
  input  logic [REG_WIDTH-1:0]             branch_offset,
  input  logic [REG_WIDTH-1:0]             irq_vector,
  input  logic                             ras_err_clr,
  output logic [REG_WIDTH-1:0]             PC_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0] ras_depth,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int NLANES = REG_WIDTH / 8;
  localparam logic [REG_WIDTH-1:0] INC = REG_WIDTH'(PC_INC);

  pc_op_e               op_s;
  logic [REG_WIDTH-1:0] pc_r;
  logic [REG_WIDTH-1:0] pc_next_s;
  logic [REG_WIDTH-1:0] pc_inc_s;
  logic [REG_WIDTH-1:0] pc_rel_s;
  logic [REG_WIDTH-1:0] wr_merge_s;
  logic [REG_WIDTH-1:0] push_data_s;
  logic [REG_WIDTH-1:0] pop_data_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 ras_empty_s;
  logic                 ovf_evt_s;
  logic                 unf_evt_s;
  logic                 overflow_r;
  logic                 underflow_r;

  assign op_s     = pc_op_decode(|reg_wr_en, irq_en, ret_en, call_en, branch_en, fetch_en);
  assign pc_inc_s = pc_r + INC;
  assign pc_rel_s = pc_r + branch_offset;

  // byte-lane merge of direct write data over the current PC
  always_comb begin
    wr_merge_s = pc_r;
    for (int i = 0; i < NLANES; i++) begin
      if (reg_wr_en[i]) wr_merge_s[8*i +: 8] = reg_in[8*i +: 8];
      else              wr_merge_s[8*i +: 8] = pc_r[8*i +: 8];
    end
  end

  // next-PC selection and stack requests
  always_comb begin
    pc_next_s   = pc_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    push_data_s = pc_inc_s;
    case (op_s)
      PC_REGWR: pc_next_s = wr_merge_s;
      PC_IRQ: begin
        push_s      = 1'b1;
        push_data_s = pc_r;   // interrupted instruction is re-executed on return
        pc_next_s   = irq_vector;
      end
      PC_RET: begin
        pop_s     = 1'b1;
        pc_next_s = ras_empty_s ? pc_inc_s : pop_data_s;
      end
      PC_CALL: begin
        push_s      = 1'b1;
        push_data_s = pc_inc_s;
        pc_next_s   = pc_rel_s;
      end
      PC_BRANCH: pc_next_s = pc_rel_s;
      PC_FETCH:  pc_next_s = pc_inc_s;
      default:   pc_next_s = pc_r;
    endcase
  end

  return_address_stack #(
    .REG_WIDTH   (REG_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .pop_data  (pop_data_s),
    .depth     (ras_depth),
    .empty     (ras_empty_s),
    .overflow  (ovf_evt_s),
    .underflow (unf_evt_s)
  );

  // PC register and sticky error flags; a new error wins over a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_VECTOR;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      overflow_r  <= ovf_evt_s | (overflow_r & ~ras_err_clr);
      underflow_r <= unf_evt_s | (underflow_r & ~ras_err_clr);
    end
  end

  assign PC_out        = pc_r;
  assign ras_overflow  = overflow_r;
  assign ras_underflow = underflow_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for single-cycle behaviour plus
// hand-built sequences for stack overflow/underflow and mid-sequence reset.
module tb_pc_sequencer;

  typedef struct packed {
    logic [6:0]  ctl;   // {rst, irq, ret, call, branch, fetch, clr}
    logic [1:0]  wr;
    logic [15:0] din;
    logic [15:0] off;
    logic [15:0] irqv;
    logic [15:0] exp_pc;
    logic [3:0]  exp_d;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] RS = 7'b1000000;
  localparam logic [6:0] IQ = 7'b0100000;
  localparam logic [6:0] RT = 7'b0010000;
  localparam logic [6:0] CL = 7'b0001000;
  localparam logic [6:0] BR = 7'b0000100;
  localparam logic [6:0] FE = 7'b0000010;
  localparam logic [6:0] CR = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst, fetch_en, branch_en, call_en, ret_en, irq_en, ras_err_clr;
  logic [1:0]  reg_wr_en;
  logic [15:0] reg_in, branch_offset, irq_vector, PC_out;
  logic [3:0]  ras_depth;
  logic        ras_overflow, ras_underflow;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .REG_WIDTH    (16),
    .STACK_DEPTH  (8),
    .RESET_VECTOR (16'h0100),
    .PC_INC       (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_en      (fetch_en),
    .branch_en     (branch_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .irq_en        (irq_en),
    .reg_wr_en     (reg_wr_en),
    .reg_in        (reg_in),
    .branch_offset (branch_offset),
    .irq_vector    (irq_vector),
    .ras_err_clr   (ras_err_clr),
    .PC_out        (PC_out),
    .ras_depth     (ras_depth),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    {rst, irq_en, ret_en, call_en, branch_en, fetch_en, ras_err_clr} = v.ctl;
    reg_wr_en     = v.wr;
    reg_in        = v.din;
    branch_offset = v.off;
    irq_vector    = v.irqv;
    @(posedge clk);
    #1;
    chk({tag, ".pc"},    PC_out, v.exp_pc);
    chk({tag, ".depth"}, {12'h000, ras_depth}, {12'h000, v.exp_d});
    chk({tag, ".ovf"},   {15'h0000, ras_overflow}, {15'h0000, v.exp_ovf});
    chk({tag, ".unf"},   {15'h0000, ras_underflow}, {15'h0000, v.exp_unf});
  endtask

  vec_t        vt [22];
  logic [15:0] e;
  logic [3:0]  d;

  initial begin
    {rst, irq_en, ret_en, call_en, branch_en, fetch_en, ras_err_clr} = 7'b0000000;
    reg_wr_en = 2'b00; reg_in = 16'h0000; branch_offset = 16'h0000; irq_vector = 16'h0000;

    //          ctl      wr     din       off       irqv      exp_pc    d     ovf   unf
    vt[0]  = '{RS,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0};
    vt[1]  = '{FE,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0102, 4'd0, 1'b0, 1'b0};
    vt[2]  = '{FE,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0104, 4'd0, 1'b0, 1'b0};
    vt[3]  = '{FE,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0106, 4'd0, 1'b0, 1'b0};
    vt[4]  = '{BR,      2'b00, 16'h0000, 16'hFFFA, 16'h0000, 16'h0100, 4'd0, 1'b0, 1'b0};
    vt[5]  = '{NO,      2'b11, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE, 4'd0, 1'b0, 1'b0};
    vt[6]  = '{FE,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0};
    vt[7]  = '{NO,      2'b11, 16'h0200, 16'h0000, 16'h0000, 16'h0200, 4'd0, 1'b0, 1'b0};
    vt[8]  = '{CL,      2'b00, 16'h0000, 16'h0040, 16'h0000, 16'h0240, 4'd1, 1'b0, 1'b0};
    vt[9]  = '{RT,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0202, 4'd0, 1'b0, 1'b0};
    vt[10] = '{NO,      2'b11, 16'h1234, 16'h0000, 16'h0000, 16'h1234, 4'd0, 1'b0, 1'b0};
    vt[11] = '{FE,      2'b10, 16'hABCD, 16'h0000, 16'h0000, 16'hAB34, 4'd0, 1'b0, 1'b0};
    vt[12] = '{IQ | RT, 2'b00, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 4'd1, 1'b0, 1'b0};
    vt[13] = '{RT,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB34, 4'd0, 1'b0, 1'b0};
    vt[14] = '{BR | FE, 2'b00, 16'h0000, 16'h0010, 16'h0000, 16'hAB44, 4'd0, 1'b0, 1'b0};
    vt[15] = '{CL | BR, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'hAB48, 4'd1, 1'b0, 1'b0};
    vt[16] = '{NO,      2'b01, 16'h00FF, 16'h0000, 16'h0000, 16'hABFF, 4'd1, 1'b0, 1'b0};
    vt[17] = '{RT,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB46, 4'd0, 1'b0, 1'b0};
    vt[18] = '{RT,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB48, 4'd0, 1'b0, 1'b1};
    vt[19] = '{RT | CR, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB4A, 4'd0, 1'b0, 1'b1};
    vt[20] = '{CR,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB4A, 4'd0, 1'b0, 1'b0};
    vt[21] = '{NO,      2'b00, 16'h0000, 16'h0000, 16'h0000, 16'hAB4A, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 22; i++) apply(vt[i], $sformatf("vec%0d", i));

    // nine calls into an eight-entry stack
    apply('{NO, 2'b11, 16'h1000, 16'h0000, 16'h0000, 16'h1000, 4'd0, 1'b0, 1'b0}, "ovf.load");
    for (int k = 1; k <= 9; k++) begin
      e = 16'(16'h1000 + 16'h0010 * k);
      d = (k > 8) ? 4'd8 : 4'(k);
      apply('{CL, 2'b00, 16'h0000, 16'h0010, 16'h0000, e, d, (k == 9), 1'b0},
            $sformatf("ovf.call%0d", k));
    end
    // returns unwind calls 9..2; call k pushed 0x1000 + 0x10*(k-1) + 2
    for (int j = 1; j <= 8; j++) begin
      e = 16'(16'h1000 + 16'h0010 * (9 - j) + 16'h0002);
      d = 4'(8 - j);
      apply('{RT, 2'b00, 16'h0000, 16'h0000, 16'h0000, e, d, 1'b1, 1'b0},
            $sformatf("ovf.ret%0d", j));
    end
    apply('{RT, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1014, 4'd0, 1'b1, 1'b1}, "unf.ret9");
    apply('{CR, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h1014, 4'd0, 1'b0, 1'b0}, "unf.clr");

    // reset in the middle of a call chain, with other requests also asserted
    apply('{NO, 2'b11, 16'h2000, 16'h0000, 16'h0000, 16'h2000, 4'd0, 1'b0, 1'b0}, "rst.load");
    for (int k = 1; k <= 3; k++) begin
      e = 16'(16'h2000 + 16'h0100 * k);
      apply('{CL, 2'b00, 16'h0000, 16'h0100, 16'h0000, e, 4'(k), 1'b0, 1'b0},
            $sformatf("rst.call%0d", k));
    end
    apply('{RS | CL | IQ, 2'b11, 16'h5555, 16'h0100, 16'h0040, 16'h0100, 4'd0, 1'b0, 1'b0},
          "rst.mid");
    apply('{RT, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0102, 4'd0, 1'b0, 1'b1}, "rst.ret");

    // call and return across the top of the address space
    apply('{NO, 2'b11, 16'hFFFE, 16'h0000, 16'h0000, 16'hFFFE, 4'd0, 1'b0, 1'b1}, "wrap.load");
    apply('{CL, 2'b00, 16'h0000, 16'h0004, 16'h0000, 16'h0002, 4'd1, 1'b0, 1'b1}, "wrap.call");
    apply('{RT, 2'b00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b1}, "wrap.ret");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
